// File: rtl/limn2600_bus_pkg.sv
// Shared types and constants for the Limn2600 bus initiator and its lane mux.
package limn2600_bus_pkg;

  localparam int WORD_W  = 32;
  localparam int LANE_W  = 8;
  // Counter wide enough for any legal TIMEOUT (1..255).
  localparam int TMO_MAX = 255;
  localparam int TMO_CW  = $clog2(TMO_MAX + 1);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_ALIGN   = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_SIZE    = 2'b11
  } err_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_CS,
    S_RD_WAIT,
    S_WR_CS,
    S_WR_WAIT,
    S_RMW_RD_CS,
    S_RMW_RD_WAIT,
    S_RMW_WR_CS,
    S_RMW_WR_WAIT,
    S_RESP
  } init_state_e;

endpackage

// File: rtl/limn2600_lane_mux.sv
// Little-endian lane extract (zero-extended) and lane insert for byte/half/word.
module limn2600_lane_mux
  import limn2600_bus_pkg::*;
(
  input  size_e              size,
  input  logic [1:0]         lane,
  input  logic [WORD_W-1:0]  word,
  input  logic [WORD_W-1:0]  data,
  output logic [WORD_W-1:0]  rdata,
  output logic [WORD_W-1:0]  merged
);

  logic [4:0]        sh;
  logic [WORD_W-1:0] shifted;
  logic [WORD_W-1:0] mask;

  always_comb begin
    sh      = {lane, 3'b000};
    shifted = word >> sh;
    rdata   = word;
    mask    = '1;
    case (size)
      SZ_BYTE: begin
        rdata = {{(WORD_W-LANE_W){1'b0}}, shifted[LANE_W-1:0]};
        mask  = 32'h0000_00ff << sh;
      end
      SZ_HALF: begin
        rdata = {{(WORD_W-2*LANE_W){1'b0}}, shifted[2*LANE_W-1:0]};
        mask  = 32'h0000_ffff << sh;
      end
      default: ;
    endcase
    merged = (word & ~mask) | ((data << sh) & mask);
  end

endmodule

// File: rtl/limn2600_bus_initiator.sv
// CPU load/store to Limn2600 chip-select bus initiator; sub-word stores use read-modify-write.
module limn2600_bus_initiator
  import limn2600_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [1:0]            resp_err,
  output logic                  bus_cs,
  output logic                  bus_we,
  output logic [31:0]           bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_rdy
);

  localparam logic [TMO_CW-1:0] TMO_LIM = TMO_CW'(TIMEOUT);

  init_state_e           state, state_nxt;
  logic [TMO_CW-1:0]     cnt, cnt_nxt, cnt_inc;
  size_e                 r_size;
  logic [1:0]            r_lane;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  lat_en;

  logic                  req_ready_d, resp_valid_d, bus_cs_d, bus_we_d;
  logic [DATA_WIDTH-1:0] resp_rdata_d, bus_wdata_d;
  err_e                  resp_err_d;
  logic [31:0]           bus_addr_d;
  logic [DATA_WIDTH-1:0] lane_rdata, lane_merged;
  logic                  misalign;

  limn2600_lane_mux u_lane (
    .size   (r_size),
    .lane   (r_lane),
    .word   (bus_rdata),
    .data   (r_wdata),
    .rdata  (lane_rdata),
    .merged (lane_merged)
  );

  assign misalign = (req_size == SZ_HALF && req_addr[0]) ||
                    (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
  assign cnt_inc  = cnt + 1'b1;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    lat_en       = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = ERR_OK;
    bus_addr_d   = bus_addr;
    bus_wdata_d  = bus_wdata;
    case (state)
      S_IDLE: if (req_valid && req_ready) begin
        lat_en      = 1'b1;
        bus_addr_d  = {req_addr[31:2], 2'b00};
        bus_wdata_d = req_wdata;
        if (req_size == SZ_RSVD) begin
          state_nxt  = S_RESP;
          resp_err_d = ERR_SIZE;
        end else if (misalign) begin
          state_nxt  = S_RESP;
          resp_err_d = ERR_ALIGN;
        end else if (!req_we)             state_nxt = S_RD_CS;
        else if (req_size == SZ_WORD)     state_nxt = S_WR_CS;
        else                              state_nxt = S_RMW_RD_CS;
      end
      S_RD_CS:     begin state_nxt = S_RD_WAIT;     cnt_nxt = '0; end
      S_WR_CS:     begin state_nxt = S_WR_WAIT;     cnt_nxt = '0; end
      S_RMW_RD_CS: begin state_nxt = S_RMW_RD_WAIT; cnt_nxt = '0; end
      S_RMW_WR_CS: begin state_nxt = S_RMW_WR_WAIT; cnt_nxt = '0; end
      S_RD_WAIT, S_WR_WAIT, S_RMW_RD_WAIT, S_RMW_WR_WAIT: begin
        // rdy wins over a timeout landing in the same cycle
        if (bus_rdy) begin
          if (state == S_RMW_RD_WAIT) begin
            state_nxt   = S_RMW_WR_CS;
            bus_wdata_d = lane_merged;
          end else begin
            state_nxt = S_RESP;
            if (state == S_RD_WAIT) resp_rdata_d = lane_rdata;
          end
        end else if (cnt_inc == TMO_LIM) begin
          state_nxt  = S_RESP;
          resp_err_d = ERR_TIMEOUT;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Outputs are registered, so they are decoded from the next state.
    req_ready_d  = (state_nxt == S_IDLE);
    resp_valid_d = (state_nxt == S_RESP);
    bus_cs_d     = (state_nxt == S_RD_CS) || (state_nxt == S_WR_CS) ||
                   (state_nxt == S_RMW_RD_CS) || (state_nxt == S_RMW_WR_CS);
    bus_we_d     = (state_nxt == S_WR_CS) || (state_nxt == S_RMW_WR_CS);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      r_size     <= SZ_BYTE;
      r_lane     <= '0;
      r_wdata    <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= ERR_OK;
      bus_cs     <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      resp_err   <= resp_err_d;
      bus_cs     <= bus_cs_d;
      bus_we     <= bus_we_d;
      bus_addr   <= bus_addr_d;
      bus_wdata  <= bus_wdata_d;
      if (lat_en) begin
        r_size  <= size_e'(req_size);
        r_lane  <= req_addr[1:0];
        r_wdata <= req_wdata;
      end
    end
  end

endmodule
